aes_enc_out_collector: RTL

Output stage placed directly downstream of the pipelined AES-128 encryptor. It tracks the encryptor's per-block enable through a delay line that matches the pipeline depth. It captures each finished 128-bit ciphertext when it emerges from the last round, buffers it in a small FIFO, and streams it out as 32-bit words over a valid/ready handshake with an end-of-block marker.

---
 rtl/aes_enc_out_collector_if.sv | 37 +++
 rtl/aes_enc_out_collector.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/aes_enc_out_collector_if.sv
// ---------------------------------------------------------------------------
// aes_enc_out_collector_if
//
// Word-stream handshake bundle between the AES output collector and its sink.
//
// Signals:
//   m_data   WORD bits  current output word (collector -> sink)
//   m_valid  1 bit      m_data is valid        (collector -> sink)
//   m_last   1 bit      final word of a block  (collector -> sink)
//   m_ready  1 bit      sink accepts the word  (sink -> collector)
//
// Modports:
//   master  used by the collector (drives data/valid/last, samples ready)
//   slave   used by the sink      (samples data/valid/last, drives ready)
// ---------------------------------------------------------------------------
interface aes_enc_out_collector_if #(
    parameter int WORD = 32
) ();
    logic [WORD-1:0] m_data;
    logic            m_valid;
    logic            m_last;
    logic            m_ready;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/aes_enc_out_collector.sv
// ---------------------------------------------------------------------------
// aes_enc_out_collector
//
// Output stage behind the pipelined AES-128 encryptor. The encryptor's
// per-block enable is tracked through a LATENCY-deep delay line; when the
// delayed enable pops out, the finished ciphertext on ct_in is written into a
// small block FIFO. The FIFO head is streamed out MSW first as WORD-bit words
// over a valid/ready handshake, with m_last marking the final word.
//
// Parameters:
//   BLOCK_LENGTH  ciphertext width (multiple of WORD)
//   WORD          output word width
//   LATENCY       enable-to-ciphertext delay of the encryptor (>= 1)
//   DEPTH         FIFO depth in blocks (power of 2, >= 2)
//
// Ports:
//   clk         clock
//   rst         asynchronous active-low reset
//   enable_in   encryptor enable; 1 = a block enters the encryptor this cycle
//   ct_in       final-round ciphertext from the encryptor
//   m_if        word stream (master modport): m_data, m_valid, m_last, m_ready
//   fifo_level  blocks stored, including the one being streamed
//   err         sticky overflow flag
//
// Build option:
//   AES_OUT_ERR_EN  when defined, err latches high on the first dropped block
//                   until reset; otherwise err is tied low. Blocks that arrive
//                   into a full FIFO are dropped in both builds.
// ---------------------------------------------------------------------------
module aes_enc_out_collector #(
    parameter int BLOCK_LENGTH = 128,
    parameter int WORD         = 32,
    parameter int LATENCY      = 11,
    parameter int DEPTH        = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable_in,
    input  logic [BLOCK_LENGTH-1:0]   ct_in,
    aes_enc_out_collector_if.master   m_if,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      err
);

    localparam int NWORDS = BLOCK_LENGTH / WORD;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [LATENCY-1:0]      vld;
    logic                    cap;
    logic [BLOCK_LENGTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [IDX_W-1:0]        idx;
    logic [BLOCK_LENGTH-1:0] head;
    logic [WORD-1:0]         word;
    logic                    valid;
    logic                    last;
    logic                    xfer;
    logic                    pop;
    logic                    wr_en;

    // Delay line mirroring the encryptor pipeline: a bit entering at vld[0]
    // reaches the tap exactly when its ciphertext is on ct_in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
        end else begin
            vld[0] <= enable_in;
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    assign cap = vld[LATENCY-1];

    // Handshake decode. A pop happens only when the head's last word moves.
    assign valid = (count != '0);
    assign last  = valid && (idx == LAST_IDX);
    assign xfer  = valid && m_if.m_ready;
    assign pop   = xfer && last;

    // A full FIFO still takes a new block when the head leaves in the same
    // cycle; the write then lands in the slot being vacated (wr_ptr == rd_ptr).
    assign wr_en = cap && ((count < DEPTH_CNT) || pop);

    // Storage is reset so the idle output word reads as zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= ct_in;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Word index over the head block; returns to 0 when the block is popped,
    // so an empty FIFO always leaves idx at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (pop) begin
            idx <= '0;
        end else if (xfer) begin
            idx <= idx + 1'b1;
        end
    end

    assign head = mem[rd_ptr];

    // Word 0 is the most significant slice of the block.
    always_comb begin
        word = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (idx == IDX_W'(i)) begin
                word = head[BLOCK_LENGTH-1-i*WORD -: WORD];
            end
        end
    end

    assign m_if.m_data  = word;
    assign m_if.m_valid = valid;
    assign m_if.m_last  = last;
    assign fifo_level   = count;

`ifdef AES_OUT_ERR_EN
    logic drop;

    assign drop = cap && !wr_en;

    // Sticky: only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (drop) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
